if_pc_stage: RTL
================

# if_pc_stage

Fetch-stage sequencer for the five-stage MIPS pipeline. It owns the PC register that addresses instruction memory, computes the next PC from the decode-stage redirect request, and latches the fetched word into the IF/ID pipeline register. It also halts fetch when the PC leaves the instruction-memory window, which is word-addressed and begins at 0x0000_3000.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, first byte address backed by instruction memory.
- IM_WORDS, 4096, instruction-memory depth in words; valid window is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds the PC and IF/ID.
- npc_sel  in  2  next-PC source, from decode: 00 PC+4, 01 branch, 10 j/jal, 11 jr/jalr.
- br_taken  in  1  branch comparison result from decode; only used when npc_sel=01.
- jr_target  in  32  forwarded register value for jr/jalr.
- instr_F  in  32  word read from instruction memory at pc_F, combinational.
- pc_F  out  32  current fetch PC, drives instruction memory.
- instr_D  out  32  IF/ID instruction.
- pc_D  out  32  IF/ID PC.
- pc8_D  out  32  pc_D + 8, the link value.
- halted  out  1  fetch halted after an address fault.
- fault_pc  out  32  offending PC captured at the fault.

## Operation
- Two states:
  - RUN: normal fetch.
  - HALT: entered on an address fault; left only by reset.
- pc_F is valid when all three hold:
  - pc_F[1:0] = 0
  - pc_F >= IM_BASE
  - pc_F < IM_BASE + 4*IM_WORDS
- Next PC is computed from the IF/ID contents, because the branch delay slot is architectural and nothing is flushed.
  - 00: pc_F + 4.
  - 01: if br_taken, pc_D + 4 + sign_ext(instr_D[15:0]) << 2; otherwise pc_F + 4.
  - 10: {pc_D[31:28], instr_D[25:0], 2'b00}.
  - 11: jr_target, used unmodified.
- Per-edge priority, highest first:
  - reset;
  - HALT;
  - stall;
  - fault (RUN with pc_F invalid);
  - normal update.
- Per-case behaviour:
  - reset: pc_F = RESET_PC, instr_D = 0, pc_D = 0, fault_pc = 0, state = RUN.
  - HALT: every register holds.
  - stall: pc_F, instr_D, pc_D hold; npc_sel is ignored this cycle.
  - fault: instr_D = 0 (nop); pc_D = pc_F; fault_pc = pc_F; pc_F holds; state becomes HALT.
  - normal: instr_D = instr_F, pc_D = pc_F, pc_F = next PC.
- The fault check uses the current pc_F, not the next PC. An invalid target is therefore loaded first, and the fault is raised on the following edge.
- All 32-bit sums wrap modulo 2^32. The branch offset is 18 bits after the shift and is sign-extended to 32.
- pc8_D is combinational from pc_D.
- halted = (state == HALT), combinational.

## Timing
- Reset values:
  - pc_F = RESET_PC
  - instr_D = 0
  - pc_D = 0
  - pc8_D = 8
  - halted = 0
  - fault_pc = 0
- Fetch latency: the word at pc_F appears on instr_D one edge later.
- Redirect: the target appears on pc_F at the edge after decode presents npc_sel. This is the same edge that loads the delay-slot instruction into IF/ID.
- Stall asserted for N cycles freezes all outputs for exactly N edges. On the first edge with stall low, the request held in decode is applied.
- Stall and fault in the same cycle: stall wins and the fault is deferred.
- Reset asserted mid-operation, including in HALT, overrides everything on that edge.

## Test plan
- Reset and sequential fetch:
  - Stimulus: reset 2 cycles, then run with npc_sel=00.
  - Required: pc_F goes 0x3000, 0x3004, 0x3008.
  - Required: instr_D at the third edge is the word fetched at 0x3004; pc8_D = 0x300C.
- Stall:
  - Stimulus: stall for 3 cycles with pc_F = 0x3010.
  - Required: pc_F, instr_D and pc_D are unchanged for 3 edges, then pc_F = 0x3014.
- Taken backward branch:
  - Stimulus: pc_D = 0x3020, instr_D[15:0] = 0xFFFC, npc_sel=01, br_taken=1.
  - Required: pc_F becomes 0x3014.
  - Required: with br_taken=0, pc_F becomes current pc_F + 4.
- j and jr:
  - Stimulus j: pc_D = 0x3040, instr_D[25:0] = 0x0000C10.
  - Required: pc_F = 0x0000_3040.
  - Stimulus jr: jr_target = 0x3100.
  - Required: pc_F = 0x3100.
- Fault:
  - Stimulus: jr_target = 0x7000 with npc_sel=11.
  - Required: pc_F = 0x7000 after one edge.
  - Required: after the next edge, halted = 1, fault_pc = 0x7000, instr_D = 0, and pc_F stays 0x7000 for 5 further cycles.
  - Also cover a misaligned jr_target of 0x3002, which must fault the same way.
- Reset in HALT:
  - Stimulus: assert reset while halted.
  - Required: on the next edge, halted = 0, pc_F = 0x3000, fault_pc = 0.

Source files
------------

// File: rtl/if_pc_stage.sv
// if_pc_stage: MIPS fetch-stage PC register, next-PC select, IF/ID latch and address-fault halt.
module if_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] jr_target,
  input  logic [31:0] instr_F,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        halted,
  output logic [31:0] fault_pc
);
  typedef enum logic {RUN, HALT} state_t;
  // 33-bit end address so a window reaching the top of the address space cannot wrap
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;
  state_t state, state_n;
  logic [31:0] pc_n, instr_n, pcd_n, fault_n, seq_pc, br_pc, j_pc, target;
  logic valid;
  assign valid  = pc_F[1:0] == 2'b00 && pc_F >= IM_BASE && {1'b0, pc_F} < IM_END;
  assign seq_pc = pc_F + 32'd4;
  assign br_pc  = pc_D + 32'd4 + {{14{instr_D[15]}}, instr_D[15:0], 2'b00};
  assign j_pc   = {pc_D[31:28], instr_D[25:0], 2'b00};
  assign target = npc_sel == 2'b00 ? seq_pc :
                  npc_sel == 2'b01 ? (br_taken ? br_pc : seq_pc) :
                  npc_sel == 2'b10 ? j_pc : jr_target;
  always_comb begin
    state_n = state;
    pc_n    = pc_F;
    instr_n = instr_D;
    pcd_n   = pc_D;
    fault_n = fault_pc;
    if (state == RUN && !stall) begin
      pcd_n   = pc_F;
      instr_n = valid ? instr_F : 32'd0;
      pc_n    = valid ? target : pc_F;
      fault_n = valid ? fault_pc : pc_F;
      state_n = valid ? RUN : HALT;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc_F     <= RESET_PC;
      instr_D  <= '0;
      pc_D     <= '0;
      fault_pc <= '0;
    end else begin
      state    <= state_n;
      pc_F     <= pc_n;
      instr_D  <= instr_n;
      pc_D     <= pcd_n;
      fault_pc <= fault_n;
    end
  end
  assign pc8_D  = pc_D + 32'd8;
  assign halted = state == HALT;
endmodule
